// File: rtl/imu_frame_unpack.sv
// IMU burst unpacker: assembles 14-byte MPU register bursts into signed samples,
// removes stored biases with saturation, and derives those biases by averaging frames.
module imu_frame_unpack #(
    parameter int TIMEOUT_CYC = 2000,
    parameter int CAL_LOG2    = 6,
    parameter int ACC_1G      = 16384
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               frame_start,
    input  logic               byte_valid,
    input  logic [7:0]         byte_data,
    input  logic               cal_req,
    output logic signed [15:0] acc_x,
    output logic signed [15:0] acc_y,
    output logic signed [15:0] acc_z,
    output logic signed [15:0] gyr_x,
    output logic signed [15:0] gyr_y,
    output logic signed [15:0] gyr_z,
    output logic signed [15:0] temp,
    output logic               sample_valid,
    output logic               cal_busy,
    output logic               cal_done,
    output logic               frame_err
);

    localparam int NBYTES = 14;
    localparam int AW     = 16 + CAL_LOG2;
    localparam int TW     = $clog2(TIMEOUT_CYC + 1);
    localparam int CW     = CAL_LOG2 + 1;

    localparam logic [3:0]         LAST_IDX = 4'(NBYTES - 1);
    localparam logic [TW-1:0]      TMO_LAST = TW'(TIMEOUT_CYC - 1);
    localparam logic [CW-1:0]      CAL_LAST = CW'((1 << CAL_LOG2) - 1);
    localparam logic signed [15:0] ONE_G    = 16'(ACC_1G);

    typedef enum logic [1:0] {
        IDLE,
        COLLECT,
        PROCESS
    } state_t;

    state_t                state;
    logic [3:0]            idx;
    logic [TW-1:0]         tmo_cnt;
    logic [CW-1:0]         cal_cnt;
    logic [7:0]            raw_buf  [NBYTES];
    logic signed [15:0]    bias     [6];
    logic signed [AW-1:0]  acc      [6];
    logic signed [15:0]    out_axis [6];
    logic signed [15:0]    out_temp;

    logic                  buf_we;
    logic [3:0]            buf_idx;
    logic signed [15:0]    raw_axis [6];
    logic signed [15:0]    raw_temp;
    logic signed [16:0]    diff     [6];
    logic signed [15:0]    corr     [6];
    logic signed [AW-1:0]  acc_next [6];
    logic signed [15:0]    bias_new [6];

    function automatic logic signed [15:0] sat16(input logic signed [16:0] v);
        // Disagreeing top bits mean the 17-bit difference left the 16-bit range.
        if (v[16] != v[15]) begin
            return v[16] ? 16'sh8000 : 16'sh7fff;
        end
        return v[15:0];
    endfunction

    // A start pulse always claims the byte slot 0, even in PROCESS or IDLE.
    always_comb begin
        // NOTE: every signal driven here gets a default first, so no path can leave one unassigned and infer a latch.
        buf_we  = 1'b0;
        buf_idx = idx;
        if (!rst && byte_valid) begin
            if (frame_start) begin
                buf_we  = 1'b1;
                buf_idx = 4'd0;
            end else if (state == COLLECT) begin
                buf_we = 1'b1;
            end
        end
    end

    // NOTE: the byte buffer is plain data storage with no reset; nothing reads it before a full burst has been written.
    always_ff @(posedge clk) begin
        if (buf_we) begin
            raw_buf[buf_idx] <= byte_data;
        end
    end

    // Axis a maps to burst word a for accel and word a+1 for gyro (temp sits at word 3).
    always_comb begin
        raw_temp = {raw_buf[6], raw_buf[7]};
        for (int a = 0; a < 6; a++) begin
            raw_axis[a] = {raw_buf[(a < 3) ? 2 * a : 2 * a + 2],
                           raw_buf[(a < 3) ? 2 * a + 1 : 2 * a + 3]};
            diff[a]     = 17'(raw_axis[a]) - 17'(bias[a]);
            corr[a]     = sat16(diff[a]);
            acc_next[a] = acc[a] + AW'(raw_axis[a]);
            bias_new[a] = 16'(acc_next[a] >>> CAL_LOG2) - ((a == 2) ? ONE_G : 16'sd0);
        end
    end

    // NOTE: all state below uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        sample_valid <= 1'b0;
        cal_done     <= 1'b0;
        frame_err    <= 1'b0;
        if (rst) begin
            state    <= IDLE;
            idx      <= 4'd0;
            tmo_cnt  <= '0;
            cal_cnt  <= '0;
            cal_busy <= 1'b0;
            out_temp <= '0;
            for (int a = 0; a < 6; a++) begin
                bias[a]     <= '0;
                acc[a]      <= '0;
                out_axis[a] <= '0;
            end
        end else begin
            case (state)
                IDLE: begin
                    if (frame_start) begin
                        state   <= COLLECT;
                        idx     <= byte_valid ? 4'd1 : 4'd0;
                        tmo_cnt <= '0;
                    end else if (byte_valid) begin
                        frame_err <= 1'b1;
                    end
                end

                COLLECT: begin
                    if (frame_start) begin
                        frame_err <= (idx != 4'd0);
                        idx       <= byte_valid ? 4'd1 : 4'd0;
                        tmo_cnt   <= '0;
                    end else if (byte_valid) begin
                        tmo_cnt <= '0;
                        if (idx == LAST_IDX) begin
                            state <= PROCESS;
                            idx   <= 4'd0;
                        end else begin
                            idx <= idx + 4'd1;
                        end
                    end else if (tmo_cnt == TMO_LAST) begin
                        frame_err <= 1'b1;
                        state     <= IDLE;
                        idx       <= 4'd0;
                        tmo_cnt   <= '0;
                    end else begin
                        tmo_cnt <= tmo_cnt + TW'(1);
                    end
                end

                PROCESS: begin
                    if (cal_busy) begin
                        // Calibration frames feed the accumulators; published outputs hold.
                        for (int a = 0; a < 6; a++) begin
                            acc[a] <= acc_next[a];
                        end
                        cal_cnt <= cal_cnt + CW'(1);
                        if (cal_cnt == CAL_LAST) begin
                            for (int a = 0; a < 6; a++) begin
                                bias[a] <= bias_new[a];
                            end
                            cal_busy <= 1'b0;
                            cal_done <= 1'b1;
                        end
                    end else begin
                        for (int a = 0; a < 6; a++) begin
                            out_axis[a] <= corr[a];
                        end
                        out_temp     <= raw_temp;
                        sample_valid <= 1'b1;
                    end

                    if (frame_start) begin
                        state   <= COLLECT;
                        idx     <= byte_valid ? 4'd1 : 4'd0;
                        tmo_cnt <= '0;
                    end else begin
                        state     <= IDLE;
                        idx       <= 4'd0;
                        frame_err <= byte_valid;
                    end
                end

                default: begin
                    state <= IDLE;
                    idx   <= 4'd0;
                end
            endcase

            if (cal_req && !cal_busy) begin
                for (int a = 0; a < 6; a++) begin
                    acc[a] <= '0;
                end
                cal_cnt  <= '0;
                cal_busy <= 1'b1;
            end
        end
    end

    assign acc_x = out_axis[0];
    assign acc_y = out_axis[1];
    assign acc_z = out_axis[2];
    assign gyr_x = out_axis[3];
    assign gyr_y = out_axis[4];
    assign gyr_z = out_axis[5];
    assign temp  = out_temp;

endmodule

// File: tb/tb_imu_frame_unpack.sv
// Randomized bench for imu_frame_unpack: a frame-level model (plain integer
// arithmetic on whole samples) predicts every published sample and bias.
module tb_imu_frame_unpack;

    localparam int TIMEOUT_CYC = 50;
    localparam int CAL_LOG2    = 2;
    localparam int ACC_1G      = 16384;
    localparam int CAL_N       = 1 << CAL_LOG2;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               frame_start = 1'b0;
    logic               byte_valid = 1'b0;
    logic [7:0]         byte_data = 8'h00;
    logic               cal_req = 1'b0;
    logic signed [15:0] acc_x, acc_y, acc_z, gyr_x, gyr_y, gyr_z, temp;
    logic               sample_valid, cal_busy, cal_done, frame_err;

    int total = 0;
    int bad   = 0;
    int sv_seen = 0;
    int fe_seen = 0;
    int cd_seen = 0;

    // Frame words in burst order: acc x/y/z, temp, gyr x/y/z (0..65535).
    int fv      [7];
    int exp_out [7];
    int m_bias  [6];
    int m_sum   [6];
    int m_cnt;
    bit m_busy;

    always #5 clk = ~clk;

    imu_frame_unpack #(
        .TIMEOUT_CYC(TIMEOUT_CYC),
        .CAL_LOG2   (CAL_LOG2),
        .ACC_1G     (ACC_1G)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .frame_start (frame_start),
        .byte_valid  (byte_valid),
        .byte_data   (byte_data),
        .cal_req     (cal_req),
        .acc_x       (acc_x),
        .acc_y       (acc_y),
        .acc_z       (acc_z),
        .gyr_x       (gyr_x),
        .gyr_y       (gyr_y),
        .gyr_z       (gyr_z),
        .temp        (temp),
        .sample_valid(sample_valid),
        .cal_busy    (cal_busy),
        .cal_done    (cal_done),
        .frame_err   (frame_err)
    );

    always @(negedge clk) begin
        if (sample_valid) sv_seen++;
        if (frame_err)    fe_seen++;
        if (cal_done)     cd_seen++;
    end

    task automatic check(input string tag, input int got, input int want);
        total++;
        if (got !== want) begin
            bad++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    task automatic tick();
        @(negedge clk);
        #1;
    endtask

    function automatic int s16(input int x);
        logic [15:0] t;
        t = x[15:0];
        return int'($signed(t));
    endfunction

    function automatic int sat(input int x);
        if (x > 32767)  return 32767;
        if (x < -32768) return -32768;
        return x;
    endfunction

    function automatic int fdiv(input int s);
        int q;
        q = s / CAL_N;
        if ((s % CAL_N) != 0 && s < 0) q--;
        return q;
    endfunction

    function automatic int axis_pos(input int a);
        return (a < 3) ? a : a + 1;
    endfunction

    function automatic int got_word(input int k);
        case (k)
            0:       return int'(acc_x);
            1:       return int'(acc_y);
            2:       return int'(acc_z);
            3:       return int'(temp);
            4:       return int'(gyr_x);
            5:       return int'(gyr_y);
            default: return int'(gyr_z);
        endcase
    endfunction

    task automatic check_outputs(input string tag);
        for (int k = 0; k < 7; k++) begin
            check($sformatf("%s_w%0d", tag, k), got_word(k), exp_out[k]);
        end
    endtask

    task automatic model_reset();
        for (int a = 0; a < 6; a++) begin
            m_bias[a] = 0;
            m_sum[a]  = 0;
        end
        for (int k = 0; k < 7; k++) exp_out[k] = 0;
        m_busy = 1'b0;
        m_cnt  = 0;
    endtask

    // Frame-level model: either a calibration frame or a published sample.
    task automatic model_frame(output bit pub, output bit done);
        pub  = !m_busy;
        done = 1'b0;
        if (m_busy) begin
            for (int a = 0; a < 6; a++) m_sum[a] += s16(fv[axis_pos(a)]);
            m_cnt++;
            if (m_cnt == CAL_N) begin
                for (int a = 0; a < 6; a++)
                    m_bias[a] = s16(fdiv(m_sum[a]) - ((a == 2) ? ACC_1G : 0));
                m_busy = 1'b0;
                done   = 1'b1;
            end
        end else begin
            for (int a = 0; a < 6; a++)
                exp_out[axis_pos(a)] = sat(s16(fv[axis_pos(a)]) - m_bias[a]);
            exp_out[3] = s16(fv[3]);
        end
    endtask

    task automatic pulse_cal();
        cal_req = 1'b1;
        tick();
        cal_req = 1'b0;
        if (!m_busy) begin
            m_busy = 1'b1;
            m_cnt  = 0;
            for (int a = 0; a < 6; a++) m_sum[a] = 0;
        end
    endtask

    task automatic drive_frame(input int nbytes, input int max_gap);
        int gap;
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
        for (int i = 0; i < nbytes; i++) begin
            gap = $urandom_range(max_gap, 0);
            repeat (gap) tick();
            byte_valid = 1'b1;
            byte_data  = (i % 2 == 0) ? 8'(fv[i / 2] >> 8) : 8'(fv[i / 2]);
            tick();
            byte_valid = 1'b0;
        end
    endtask

    // Sends one complete frame and checks latency, pulses and held/updated outputs.
    task automatic run_frame(input string tag, input int max_gap);
        bit pub, done;
        int sv_at, cd_at;
        model_frame(pub, done);
        drive_frame(14, max_gap);
        sv_at = -1;
        cd_at = -1;
        for (int k = 1; k <= 6; k++) begin
            if (sample_valid && sv_at < 0) sv_at = k;
            if (cal_done && cd_at < 0)     cd_at = k;
            tick();
        end
        check({tag, "_sv_at"}, sv_at, pub ? 2 : -1);
        check({tag, "_done_at"}, cd_at, done ? 2 : -1);
        check({tag, "_busy"}, int'(cal_busy), int'(m_busy));
        check_outputs(tag);
    endtask

    task automatic fill_random();
        for (int k = 0; k < 7; k++) fv[k] = $urandom_range(65535, 0);
    endtask

    task automatic fill_zero();
        for (int k = 0; k < 7; k++) fv[k] = 0;
    endtask

    initial begin
        int sv0, fe0, cd0, k;
        model_reset();
        repeat (3) tick();
        check_outputs("reset");
        check("reset_sv", int'(sample_valid), 0);
        check("reset_busy", int'(cal_busy), 0);
        check("reset_done", int'(cal_done), 0);
        check("reset_err", int'(frame_err), 0);
        rst = 1'b0;
        tick();

        // Basic frame with a negative axis and a raw temperature word.
        fill_zero();
        fv[0] = 16'h1234;
        fv[1] = 16'hFFFE;
        fv[3] = 16'h0A0B;
        run_frame("basic", 0);
        check("basic_acc_y", int'(acc_y), -2);

        // Short frame restarted by a new frame_start.
        sv0 = sv_seen;
        fe0 = fe_seen;
        fill_random();
        drive_frame(7, 1);
        fill_random();
        run_frame("restart", 1);
        check("restart_err_cnt", fe_seen - fe0, 1);
        check("restart_sv_cnt", sv_seen - sv0, 1);

        // Stray byte in IDLE.
        fe0 = fe_seen;
        sv0 = sv_seen;
        byte_valid = 1'b1;
        byte_data  = 8'h5A;
        tick();
        byte_valid = 1'b0;
        repeat (2) tick();
        check("stray_err_cnt", fe_seen - fe0, 1);
        check("stray_sv_cnt", sv_seen - sv0, 0);

        // Timeout after 5 bytes, then a clean frame.
        fill_random();
        drive_frame(5, 0);
        k = 1;
        while (!frame_err && k < 4 * TIMEOUT_CYC) begin
            tick();
            k++;
        end
        check("timeout_seen", int'(frame_err), 1);
        check("timeout_window", int'(k >= TIMEOUT_CYC && k <= TIMEOUT_CYC + 2), 1);
        fill_random();
        run_frame("post_timeout", 2);

        // Directed calibration: gyr_z 10..13, acc_z 16390.
        sv0 = sv_seen;
        cd0 = cd_seen;
        pulse_cal();
        check("cal_busy_rise", int'(cal_busy), 1);
        for (int v = 10; v <= 13; v++) begin
            fill_zero();
            fv[2] = 16390;
            fv[6] = v;
            if (v == 12) begin
                pulse_cal();
                check("cal_req_ignored", int'(cal_busy), 1);
            end
            run_frame($sformatf("cal%0d", v), 1);
        end
        check("cal_no_sv", sv_seen - sv0, 0);
        check("cal_done_cnt", cd_seen - cd0, 1);
        fill_zero();
        fv[2] = 16390;
        fv[6] = 10;
        run_frame("after_cal", 0);
        check("after_cal_gyr_z", int'(gyr_z), -1);
        check("after_cal_acc_z", int'(acc_z), 16384);

        // Saturation: gyr_x bias +100, acc_y bias -100.
        pulse_cal();
        for (int n = 0; n < CAL_N; n++) begin
            fill_zero();
            fv[1] = 16'hFF9C;
            fv[2] = ACC_1G;
            fv[4] = 100;
            run_frame($sformatf("satcal%0d", n), 2);
        end
        fill_zero();
        fv[1] = 16'h7FF0;
        fv[2] = ACC_1G;
        fv[4] = 16'h8000;
        run_frame("sat", 0);
        check("sat_gyr_x", int'(gyr_x), -32768);
        check("sat_acc_y", int'(acc_y), 32767);

        // Random traffic with a random calibration in the middle.
        for (int n = 0; n < 24; n++) begin
            if (n == 8) pulse_cal();
            fill_random();
            run_frame($sformatf("rnd%0d", n), 3);
        end

        // Reset mid-frame clears outputs and biases.
        fill_random();
        drive_frame(5, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        tick();
        check_outputs("rst_frame");
        fill_random();
        run_frame("post_rst", 1);

        // Reset mid-calibration aborts it.
        pulse_cal();
        fill_random();
        run_frame("rstcal_a", 1);
        fill_random();
        drive_frame(3, 0);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        model_reset();
        tick();
        check("rstcal_busy", int'(cal_busy), 0);
        fill_random();
        run_frame("post_rstcal", 1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
